// File: rtl/rev_pkg.sv
// rev_pkg: shared history-op encoding and default sizes for the reversible register family
package rev_pkg;
  typedef enum logic [1:0] {OP_NONE, OP_WR, OP_UNDO} hist_op_e;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/rev_hist_reg_if.sv
// rev_hist_reg_if: request/response bundle of rev_hist_reg; master drives wr_e/undo_e/data_in, slave drives the rest
interface rev_hist_reg_if import rev_pkg::*; #(parameter int WIDTH = DEF_WIDTH, parameter int DEPTH = DEF_DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic             wr_e;
  logic             undo_e;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    hist_cnt;
  logic             hist_empty;
  logic             hist_full;
  logic             wr_err;
  logic             undo_err;
  modport master (output wr_e, undo_e, data_in, input data_out, hist_cnt, hist_empty, hist_full, wr_err, undo_err);
  modport slave (input wr_e, undo_e, data_in, output data_out, hist_cnt, hist_empty, hist_full, wr_err, undo_err);
endinterface

// File: rtl/rev_hist_lifo.sv
// rev_hist_lifo: DEPTH-entry history stack (ports: clk, clr_n, i_op, i_din -> o_dout top entry, o_cnt, o_full, o_empty)
module rev_hist_lifo import rev_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  hist_op_e         i_op,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic [CW-1:0]    o_cnt,
  output logic             o_full,
  output logic             o_empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    w_inc;
  logic [PW-1:0]    w_dec;
  // explicit wrap compares: DEPTH need not be a power of two
  assign w_inc   = (r_top == PW'(DEPTH - 1)) ? '0 : r_top + 1'b1;
  assign w_dec   = (r_top == '0) ? PW'(DEPTH - 1) : r_top - 1'b1;
  assign o_dout  = r_mem[w_dec];
  assign o_cnt   = r_cnt;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_top <= '0;
      r_cnt <= '0;
    end else if (i_op == OP_WR) begin
      r_top <= w_inc;
      r_cnt <= o_full ? r_cnt : r_cnt + 1'b1;
    end else if (i_op == OP_UNDO) begin
      r_top <= w_dec;
      r_cnt <= r_cnt - 1'b1;
    end
  // storage survives reset; it is meaningless while the count is zero
  always_ff @(posedge clk)
    if (i_op == OP_WR) r_mem[r_top] <= i_din;
endmodule

// File: rtl/rev_hist_reg.sv
// rev_hist_reg: WIDTH-bit register with DEPTH-entry undo history (ports: clk, clr_n, bus slave; define REV_HIST_WRAP_EN to let writes overwrite the oldest entry when full)
module rev_hist_reg import rev_pkg::*; #(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               DEPTH   = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic         clk,
  input logic         clr_n,
  rev_hist_reg_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef REV_HIST_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif
  logic [WIDTH-1:0] r_data;
  logic             r_wr_err;
  logic             r_undo_err;
  logic             w_do_undo;
  logic             w_do_wr;
  hist_op_e         w_op;
  logic [WIDTH-1:0] w_top_val;
  logic [CW-1:0]    w_cnt;
  logic             w_full;
  logic             w_empty;
  // undo wins over a simultaneous write
  always_comb begin
    w_do_undo = bus.undo_e && !w_empty;
    w_do_wr   = bus.wr_e && !bus.undo_e && (!w_full || WRAP);
    w_op      = w_do_undo ? OP_UNDO : w_do_wr ? OP_WR : OP_NONE;
  end
  rev_hist_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lifo (
    .clk(clk), .clr_n(clr_n), .i_op(w_op), .i_din(r_data),
    .o_dout(w_top_val), .o_cnt(w_cnt), .o_full(w_full), .o_empty(w_empty)
  );
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_data     <= RST_VAL;
      r_wr_err   <= 1'b0;
      r_undo_err <= 1'b0;
    end else begin
      r_data     <= w_do_undo ? w_top_val : w_do_wr ? bus.data_in : r_data;
      r_wr_err   <= bus.wr_e && (bus.undo_e || (w_full && !WRAP));
      r_undo_err <= bus.undo_e && w_empty;
    end
  assign bus.data_out   = r_data;
  assign bus.hist_cnt   = w_cnt;
  assign bus.hist_empty = w_empty;
  assign bus.hist_full  = w_full;
  assign bus.wr_err     = r_wr_err;
  assign bus.undo_err   = r_undo_err;
endmodule
